// File: rtl/fwd_ctrl.sv
// rtl/fwd_ctrl.sv - forwarding and load-use hazard controller for the 5-stage pipeline
//
// Tracks the destination register of the instructions in EX and EX/MEM and
// produces registered operand forward selects for the instruction entering EX.
// Forward select encoding: 2'b10 = take data_exmem, 2'b01 = take data_memwb,
// 2'b00 = take register file. 2'b11 is never produced.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   id_valid     ID stage holds a real instruction
//   id_rs/id_rt  source registers of the ID instruction
//   id_rs_used   ID instruction reads id_rs
//   id_rt_used   ID instruction reads id_rt
//   id_rd        destination register of the ID instruction
//   id_regwrite  ID instruction writes id_rd
//   id_memread   ID instruction is a load
//   flush        taken branch/jump; the ID instruction is discarded
//   mem_stall    data memory busy; whole pipeline frozen
//   fwd_A/fwd_B  operand forward selects for the instruction in EX
//   stall_id     hold PC and IF/ID this cycle (combinational)
//   ex_valid     EX slot holds a real instruction
//   stall_cnt    saturating count of load-use bubbles inserted
//   err          illegal decode: load that does not write a register
module fwd_ctrl #(
   parameter int REG_BITS = 3,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rs,
   input  logic [REG_BITS-1:0] id_rt,
   input  logic                id_rs_used,
   input  logic                id_rt_used,
   input  logic [REG_BITS-1:0] id_rd,
   input  logic                id_regwrite,
   input  logic                id_memread,
   input  logic                flush,
   input  logic                mem_stall,
   output logic [1:0]          fwd_A,
   output logic [1:0]          fwd_B,
   output logic                stall_id,
   output logic                ex_valid,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic                err
);

   // EX slot: the instruction currently in execute.
   logic                ex_v;
   logic [REG_BITS-1:0] ex_rd;
   logic                ex_rw;
   logic                ex_mr;

   // MEM slot: the instruction in EX/MEM. Its load flag is not kept because a
   // load in MEM forwards from MEM/WB exactly like an ALU result would.
   // The WB stage needs no storage: a producer there is covered by the
   // register file's write-before-read, so it never drives a forward select.
   logic                mem_v;
   logic [REG_BITS-1:0] mem_rd;
   logic                mem_rw;

   logic                luh;
   logic                ex_load;
   logic [1:0]          fwd_a_nxt;
   logic [1:0]          fwd_b_nxt;

   // Forward select for one operand, evaluated against the slots as they are
   // before this edge (they become MEM and WB once the ID instruction enters EX).
   function automatic logic [1:0] sel_for(
      input logic                used,
      input logic [REG_BITS-1:0] src,
      input logic                e_v,
      input logic [REG_BITS-1:0] e_rd,
      input logic                e_rw,
      input logic                e_mr,
      input logic                m_v,
      input logic [REG_BITS-1:0] m_rd,
      input logic                m_rw
   );
      logic hit_ex;
      logic hit_mem;
      hit_ex  = e_v & e_rw & ~e_mr & (e_rd == src);
      hit_mem = m_v & m_rw & (m_rd == src);
      if (!used)
         return 2'b00;
      else if (hit_ex)
         return 2'b10;   // younger producer wins
      else if (hit_mem)
         return 2'b01;
      else
         return 2'b00;
   endfunction

   always_comb begin
      luh = id_valid & ~flush & ex_v & ex_mr & ex_rw &
            ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));
      ex_load   = id_valid & ~flush & ~luh;
      fwd_a_nxt = sel_for(id_rs_used, id_rs, ex_v, ex_rd, ex_rw, ex_mr, mem_v, mem_rd, mem_rw);
      fwd_b_nxt = sel_for(id_rt_used, id_rt, ex_v, ex_rd, ex_rw, ex_mr, mem_v, mem_rd, mem_rw);
   end

   assign stall_id = mem_stall | luh;
   assign err      = id_valid & id_memread & ~id_regwrite;
   assign ex_valid = ex_v;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_v      <= 1'b0;
         ex_rd     <= '0;
         ex_rw     <= 1'b0;
         ex_mr     <= 1'b0;
         mem_v     <= 1'b0;
         mem_rd    <= '0;
         mem_rw    <= 1'b0;
         fwd_A     <= 2'b00;
         fwd_B     <= 2'b00;
         stall_cnt <= '0;
      end else if (!mem_stall) begin
         mem_v  <= ex_v;
         mem_rd <= ex_rd;
         mem_rw <= ex_rw;
         if (ex_load) begin
            ex_v  <= 1'b1;
            ex_rd <= id_rd;
            ex_rw <= id_regwrite;
            ex_mr <= id_memread;
            fwd_A <= fwd_a_nxt;
            fwd_B <= fwd_b_nxt;
         end else begin
            ex_v  <= 1'b0;
            ex_rd <= '0;
            ex_rw <= 1'b0;
            ex_mr <= 1'b0;
            fwd_A <= 2'b00;
            fwd_B <= 2'b00;
         end
         // flush already masks luh, so a flushed hazard is never counted
         if (luh && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb/tb_fwd_ctrl.sv - scoreboard testbench for fwd_ctrl
module tb_fwd_ctrl;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [2:0]  id_rs;
   logic [2:0]  id_rt;
   logic        id_rs_used;
   logic        id_rt_used;
   logic [2:0]  id_rd;
   logic        id_regwrite;
   logic        id_memread;
   logic        flush;
   logic        mem_stall;
   logic [1:0]  fwd_A;
   logic [1:0]  fwd_B;
   logic        stall_id;
   logic        ex_valid;
   logic [15:0] stall_cnt;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_q[$];

   fwd_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rs_used  (id_rs_used),
      .id_rt_used  (id_rt_used),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .id_memread  (id_memread),
      .flush       (flush),
      .mem_stall   (mem_stall),
      .fwd_A       (fwd_A),
      .fwd_B       (fwd_B),
      .stall_id    (stall_id),
      .ex_valid    (ex_valid),
      .stall_cnt   (stall_cnt),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the end of the sequence");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every time a new instruction lands in EX, compare its forward codes
   initial begin : monitor
      logic adv;
      logic [3:0] e;
      forever begin
         @(posedge clk);
         adv = rst & ~mem_stall;
         @(negedge clk);
         if (adv && ex_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got fwd_A=%b fwd_B=%b with no expected entry", fwd_A, fwd_B);
            end else begin
               e = exp_q.pop_front();
               if ({fwd_A, fwd_B} !== e) begin
                  errors++;
                  $display("FAIL sb_fwd: got fwd_A=%b fwd_B=%b expected fwd_A=%b fwd_B=%b",
                           fwd_A, fwd_B, e[3:2], e[1:0]);
               end
            end
         end else if (adv && !ex_valid) begin
            chk("bubble_fwd", {fwd_A, fwd_B}, 0);
         end
      end
   end

   // One cycle of ID stimulus; the expected EX response is queued when accepted
   task automatic cyc(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                      input logic rsu, input logic rtu, input logic [2:0] rd,
                      input logic rw, input logic mr, input logic fl, input logic ms,
                      input logic exp_stall, input logic exp_err,
                      input logic [1:0] efa, input logic [1:0] efb);
      id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
      id_rd = rd; id_regwrite = rw; id_memread = mr; flush = fl; mem_stall = ms;
      @(negedge clk);
      chk("stall_id", stall_id, exp_stall);
      chk("err", err, exp_err);
      if (v && !fl && !ms && !exp_stall)
         exp_q.push_back({efa, efb});
      @(posedge clk);
      #1;
   endtask

   task automatic ins(input logic [2:0] rs, input logic [2:0] rt, input logic rsu,
                      input logic rtu, input logic [2:0] rd, input logic rw,
                      input logic mr, input logic [1:0] efa, input logic [1:0] efb);
      cyc(1'b1, rs, rt, rsu, rtu, rd, rw, mr, 1'b0, 1'b0, 1'b0, mr & ~rw, efa, efb);
   endtask

   task automatic nop();
      cyc(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
   endtask

   initial begin
      rst = 1'b0;
      id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
      id_rd = 0; id_regwrite = 0; id_memread = 0; flush = 0; mem_stall = 0;

      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         id_valid = 1'($urandom); id_rs = 3'($urandom); id_rt = 3'($urandom);
         id_rs_used = 1'($urandom); id_rt_used = 1'($urandom); id_rd = 3'($urandom);
         id_regwrite = 1'($urandom); id_memread = 1'($urandom);
         flush = 1'($urandom); mem_stall = 1'($urandom);
         @(negedge clk);
         chk("rst_fwd_A", fwd_A, 0);
         chk("rst_fwd_B", fwd_B, 0);
         chk("rst_ex_valid", ex_valid, 0);
         chk("rst_stall_cnt", stall_cnt, 0);
         @(posedge clk);
         #1;
      end
      id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
      id_rd = 0; id_regwrite = 0; id_memread = 0; flush = 0; mem_stall = 0;
      rst = 1'b1;
      nop();

      // EX/MEM forward on rs: ADD r3,r1,r2 ; ADD r4,r3,r5
      ins(3'd1, 3'd2, 1, 1, 3'd3, 1, 0, 2'b00, 2'b00);
      chk("first_ex_valid", ex_valid, 1);
      ins(3'd3, 3'd5, 1, 1, 3'd4, 1, 0, 2'b10, 2'b00);
      nop(); nop();

      // EX/MEM forward on rt: ADD r3 ; ADD r4,r5,r3
      ins(3'd1, 3'd2, 1, 1, 3'd3, 1, 0, 2'b00, 2'b00);
      ins(3'd5, 3'd3, 1, 1, 3'd4, 1, 0, 2'b00, 2'b10);
      nop(); nop();

      // MEM/WB forward: ADD r2 ; NOP ; SUB r6,r2,r2
      ins(3'd1, 3'd1, 1, 1, 3'd2, 1, 0, 2'b00, 2'b00);
      nop();
      ins(3'd2, 3'd2, 1, 1, 3'd6, 1, 0, 2'b01, 2'b01);
      nop(); nop();

      // Priority: ADD r2 ; ADD r2 ; SUB r6,r2,r1
      ins(3'd1, 3'd1, 1, 1, 3'd2, 1, 0, 2'b00, 2'b00);
      ins(3'd4, 3'd5, 1, 1, 3'd2, 1, 0, 2'b00, 2'b00);
      ins(3'd2, 3'd1, 1, 1, 3'd6, 1, 0, 2'b10, 2'b00);
      nop(); nop();

      // Load-use: LD r1,(r2) ; ADD r7,r1,r0
      chk("cnt_before_luh", stall_cnt, 0);
      ins(3'd2, 3'd0, 1, 0, 3'd1, 1, 1, 2'b00, 2'b00);
      cyc(1, 3'd1, 3'd0, 1, 1, 3'd7, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00);
      chk("luh_bubble_ex_valid", ex_valid, 0);
      chk("luh_stall_cnt", stall_cnt, 1);
      ins(3'd1, 3'd0, 1, 1, 3'd7, 1, 0, 2'b01, 2'b00);
      nop(); nop();

      // mem_stall for 4 cycles between ADD r3 and ADD r4,r3,r5
      ins(3'd1, 3'd2, 1, 1, 3'd3, 1, 0, 2'b00, 2'b00);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 3'd3, 3'd5, 1, 1, 3'd4, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00);
         chk("ms_ex_valid", ex_valid, 1);
         chk("ms_fwd_A", fwd_A, 0);
         chk("ms_fwd_B", fwd_B, 0);
         chk("ms_stall_cnt", stall_cnt, 1);
      end
      ins(3'd3, 3'd5, 1, 1, 3'd4, 1, 0, 2'b10, 2'b00);
      ins(3'd3, 3'd4, 1, 1, 3'd6, 1, 0, 2'b01, 2'b10);
      nop(); nop();

      // flush with a pending load-use hazard
      ins(3'd2, 3'd0, 1, 0, 3'd1, 1, 1, 2'b00, 2'b00);
      cyc(1, 3'd1, 3'd0, 1, 0, 3'd5, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00);
      chk("flush_ex_valid", ex_valid, 0);
      chk("flush_stall_cnt", stall_cnt, 1);

      // illegal decode: load without regwrite
      ins(3'd0, 3'd0, 0, 0, 3'd2, 0, 1, 2'b00, 2'b00);
      nop(); nop(); nop();

      chk("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fwd_ctrl.md
Name: fwd_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage pipeline.
- Tracks the destination register of every in-flight instruction in EX, EX/MEM and MEM/WB.
- Produces registered fwd_A/fwd_B select codes for the execute stage:
  - fwd[1] selects data_exmem.
  - fwd[0] selects data_memwb.
  - fwd[1] has priority.
- Raises stall_id on load-use hazards and freezes all tracking on a memory stall.

Parameters:
- REG_BITS, 3, register index width (8 GPRs).
- CNT_W, 16, width of the load-use stall counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- id_valid  input  1  ID stage holds a real instruction
- id_rs  input  REG_BITS  first source register of the ID instruction
- id_rt  input  REG_BITS  second source register of the ID instruction
- id_rs_used  input  1  ID instruction reads id_rs
- id_rt_used  input  1  ID instruction reads id_rt (ALU operand B or store data)
- id_rd  input  REG_BITS  destination register of the ID instruction
- id_regwrite  input  1  ID instruction writes id_rd
- id_memread  input  1  ID instruction is a load
- flush  input  1  branch/jump resolved taken; ID instruction is discarded
- mem_stall  input  1  data memory busy; whole pipeline frozen this cycle
- fwd_A  output  2  operand A forward select for the instruction now in EX
- fwd_B  output  2  operand B forward select for the instruction now in EX
- stall_id  output  1  hold PC and IF/ID this cycle
- ex_valid  output  1  EX slot holds a real instruction
- stall_cnt  output  CNT_W  count of load-use bubbles inserted (saturating)
- err  output  1  illegal decode flag

Behaviour:
- Internal slots: ex, mem, wb.
  - Each slot holds {valid, rd, regwrite, memread}.
  - All fields reset to 0.
- Reset (rst=0, asynchronous): all slots cleared; fwd_A=fwd_B=2'b00; ex_valid=0; stall_cnt=0. Outputs stay at these values while rst=0.
- Load-use hazard, combinational:
  - luh = id_valid & ~flush & ex.valid & ex.memread & ex.regwrite & ((id_rs_used & id_rs==ex.rd) | (id_rt_used & id_rt==ex.rd)).
- stall_id = mem_stall | luh.
- Per posedge, in priority order:
  1. mem_stall=1: all slots, fwd_A, fwd_B and stall_cnt hold. Takes priority over luh and flush.
  2. Otherwise the pipeline advances: wb<=mem, mem<=ex.
  3. EX slot load:
     - If flush or luh or ~id_valid: ex<=bubble (valid=0) and fwd_A=fwd_B=00.
     - Else ex<={1, id_rd, id_regwrite, id_memread}.
  4. Forward codes for the entering instruction (X = rs for fwd_A, rt for fwd_B, gated by the matching _used flag; unused operand gives 00):
     - bit1 = old ex.valid & old ex.regwrite & ~old ex.memread & old ex.rd==X.
     - bit0 = old mem.valid & old mem.regwrite & old mem.rd==X.
     - If both match, output 10 (the younger producer wins). Never output 11.
  5. On luh (and no mem_stall): stall_cnt increments by 1 and saturates at all-ones.
- Latency:
  - fwd_A/fwd_B/ex_valid are registered: valid in the cycle the instruction is in EX, one cycle after ID evaluation.
  - stall_id is same-cycle combinational.
- Load-use costs exactly one bubble. On the retry cycle the load sits in mem, so the consumer receives fwd bit0 (MEM/WB).
- Register 0 is an ordinary register; no special casing.
- A producer that has left wb is not tracked; the register file supplies the value via write-before-read.
- err = id_valid & id_memread & ~id_regwrite (combinational). err does not alter pipeline behaviour.
- flush and luh together: flush wins; no bubble is counted.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> fwd_A=fwd_B=00, ex_valid=0, stall_cnt=0. Release -> first valid ID (rd=3, regwrite=1) gives ex_valid=1 next cycle.
- EX/MEM forward: ADD r3 then ADD r4,r3,r5 back-to-back -> second instruction in EX shows fwd_A=10, fwd_B=00. With rt=r3 instead -> fwd_B=10.
- MEM/WB forward and priority:
  - ADD r2; NOP; SUB r6,r2,r2 -> fwd_A=fwd_B=01.
  - ADD r2; ADD r2; SUB r6,r2,r1 -> fwd_A=10 (younger wins).
- Load-use: LD r1 then ADD r7,r1,r0 -> stall_id=1 for exactly one cycle, ex_valid=0 the following cycle, stall_cnt=1, then ADD in EX with fwd_A=01.
- mem_stall: assert for 4 cycles mid-sequence -> stall_id=1 and fwd/ex_valid/stall_cnt frozen all 4 cycles. Release -> the sequence completes with forwarding codes identical to the unstalled run.
- flush plus hazard: LD r1 in EX, ID reads r1, flush=1 -> stall_id=0, bubble into EX, stall_cnt unchanged. Separately, id_memread=1 with id_regwrite=0 and id_valid=1 -> err=1.
